// File: rtl/softmax_pkg.sv
// softmax_pkg: shared definitions for the softmax sequencer.
//   state_t   : controller state encoding
//   PH_*      : phase codes reported on phase_o
//   sm_clog2  : width helper for address/counter sizing (never returns < 1)
package softmax_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_MAX_FEED,
      S_MAX_WAIT,
      S_EXP_FEED,
      S_EXP_WAIT,
      S_DIV_FEED,
      S_DIV_WAIT,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [1:0] PH_IDLE = 2'd0;
   localparam logic [1:0] PH_MAX  = 2'd1;
   localparam logic [1:0] PH_EXP  = 2'd2;
   localparam logic [1:0] PH_DIV  = 2'd3;

   function automatic int unsigned sm_clog2(input int unsigned value);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/softmax_phase_feeder.sv
// softmax_phase_feeder: address counter and strobe generator shared by all
// three softmax passes.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_clear      : restart the pass (phase entry) or flush everything (abort)
//   i_enable     : the controller will be in a FEED state next cycle
//   o_addr       : buffer read address, 0..number_of_data-1
//   o_rd_en      : buffer read enable
//   o_strobe     : o_rd_en delayed one cycle (aligned with read data)
//   o_last       : o_strobe for the word at address number_of_data-1
//   o_feed_end   : the final address of the pass is being issued this cycle
module softmax_phase_feeder
   import softmax_pkg::*;
#(
   parameter int unsigned number_of_data = 10,
   parameter int unsigned addr_size      = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_clear,
   input  logic                 i_enable,
   output logic [addr_size-1:0] o_addr,
   output logic                 o_rd_en,
   output logic                 o_strobe,
   output logic                 o_last,
   output logic                 o_feed_end
);

   localparam logic [addr_size-1:0] LAST_ADDR = addr_size'(number_of_data - 1);

   logic [addr_size-1:0] r_addr;
   logic                 r_rd_en;
   logic                 r_strobe;
   logic                 r_last;
   logic                 w_at_end;

   assign w_at_end = r_rd_en && (r_addr == LAST_ADDR);

   // Clear serves both phase entry (enable=1: start at address 0) and abort
   // (enable=0: kill the read and the pending delayed strobe together).
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_addr   <= '0;
         r_rd_en  <= 1'b0;
         r_strobe <= 1'b0;
         r_last   <= 1'b0;
      end else if (i_clear) begin
         r_addr   <= '0;
         r_rd_en  <= i_enable;
         r_strobe <= 1'b0;
         r_last   <= 1'b0;
      end else begin
         r_rd_en  <= i_enable;
         r_addr   <= i_enable ? r_addr + addr_size'(1) : '0;
         r_strobe <= r_rd_en;
         r_last   <= w_at_end;
      end
   end

   assign o_addr     = r_addr;
   assign o_rd_en    = r_rd_en;
   assign o_strobe   = r_strobe;
   assign o_last     = r_last;
   assign o_feed_end = w_at_end;

endmodule

// File: rtl/softmax_controller.sv
// softmax_controller: three-pass sequencer for the softmax datapath
// (max_tree, exp/sum, divider).
//   clock_i, reset_i       : clock, asynchronous active-high reset
//   start_i, abort_i       : start request (IDLE only), synchronous abort
//   rd_en_o, rd_addr_o     : input buffer read port
//   max_start_o            : valid strobe to max_tree
//   exp_valid_o/exp_last_o : valid/last strobes to exp/sum stage
//   div_valid_o/div_last_o : valid/last strobes to divider
//   max_done_i, sum_done_i, div_done_i : per-stage completion
//   phase_o, busy_o, done_o, error_o   : status
module softmax_controller
   import softmax_pkg::*;
#(
   parameter int unsigned number_of_data = 10,
   parameter int unsigned addr_size      = sm_clog2(number_of_data),
   parameter int unsigned timeout_cycles = 64
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   input  logic                 start_i,
   input  logic                 abort_i,
   output logic                 rd_en_o,
   output logic [addr_size-1:0] rd_addr_o,
   output logic                 max_start_o,
   input  logic                 max_done_i,
   output logic                 exp_valid_o,
   output logic                 exp_last_o,
   input  logic                 sum_done_i,
   output logic                 div_valid_o,
   output logic                 div_last_o,
   input  logic                 div_done_i,
   output logic [1:0]           phase_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 error_o
);

   localparam int unsigned   TW   = sm_clog2(timeout_cycles);
   localparam logic [TW-1:0] TLIM = TW'(timeout_cycles - 1);

   state_t               r_state;
   state_t               w_next;
   logic [TW-1:0]        r_tcnt;
   logic                 r_error;
   logic                 w_timeout;
   logic                 w_abort;
   logic                 w_next_feed;
   logic                 w_clear;
   logic [addr_size-1:0] w_addr;
   logic                 w_rd_en;
   logic                 w_strobe;
   logic                 w_last;
   logic                 w_feed_end;
   logic [1:0]           w_phase;
   logic                 w_busy;
   logic                 w_done;

   assign w_timeout   = (r_tcnt == TLIM);
   assign w_abort     = abort_i && (r_state != S_IDLE);
   assign w_next_feed = w_next inside {S_MAX_FEED, S_EXP_FEED, S_DIV_FEED};
   assign w_clear     = w_abort || (w_next_feed && (w_next != r_state));

   softmax_phase_feeder #(
      .number_of_data (number_of_data),
      .addr_size      (addr_size)
   ) u_feeder (
      .i_clk      (clock_i),
      .i_rst      (reset_i),
      .i_clear    (w_clear),
      .i_enable   (w_next_feed),
      .o_addr     (w_addr),
      .o_rd_en    (w_rd_en),
      .o_strobe   (w_strobe),
      .o_last     (w_last),
      .o_feed_end (w_feed_end)
   );

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Done is tested before timeout so a coincident done still advances.
   always_comb begin
      w_next = r_state;
      if (w_abort) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:     if (start_i)    w_next = S_MAX_FEED;
            S_MAX_FEED: if (w_feed_end) w_next = S_MAX_WAIT;
            S_MAX_WAIT: if (max_done_i) w_next = S_EXP_FEED;
                        else if (w_timeout) w_next = S_ERR;
            S_EXP_FEED: if (w_feed_end) w_next = S_EXP_WAIT;
            S_EXP_WAIT: if (sum_done_i) w_next = S_DIV_FEED;
                        else if (w_timeout) w_next = S_ERR;
            S_DIV_FEED: if (w_feed_end) w_next = S_DIV_WAIT;
            S_DIV_WAIT: if (div_done_i) w_next = S_DONE;
                        else if (w_timeout) w_next = S_ERR;
            default:    w_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_phase = PH_IDLE;
      w_busy  = 1'b1;
      w_done  = 1'b0;
      case (r_state)
         S_IDLE:                 w_busy  = 1'b0;
         S_MAX_FEED, S_MAX_WAIT: w_phase = PH_MAX;
         S_EXP_FEED, S_EXP_WAIT: w_phase = PH_EXP;
         S_DIV_FEED, S_DIV_WAIT: w_phase = PH_DIV;
         S_DONE:                 w_done  = 1'b1;
         default:                ;
      endcase
   end

   // Timeout counter restarts on every state change; only WAIT states count.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         r_tcnt <= '0;
      end else if (w_next != r_state) begin
         r_tcnt <= '0;
      end else if (r_state inside {S_MAX_WAIT, S_EXP_WAIT, S_DIV_WAIT}) begin
         r_tcnt <= r_tcnt + TW'(1);
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         r_error <= 1'b0;
      end else if ((r_state == S_IDLE) && start_i) begin
         r_error <= 1'b0;
      end else if (w_next == S_ERR) begin
         r_error <= 1'b1;
      end
   end

   // The final strobe lands in the first WAIT cycle, whose phase matches.
   assign max_start_o = w_strobe && (w_phase == PH_MAX);
   assign exp_valid_o = w_strobe && (w_phase == PH_EXP);
   assign exp_last_o  = w_last   && (w_phase == PH_EXP);
   assign div_valid_o = w_strobe && (w_phase == PH_DIV);
   assign div_last_o  = w_last   && (w_phase == PH_DIV);
   assign rd_en_o     = w_rd_en;
   assign rd_addr_o   = w_addr;
   assign phase_o     = w_phase;
   assign busy_o      = w_busy;
   assign done_o      = w_done;
   assign error_o     = r_error;

endmodule
